// File: rtl/fsm_4s2i1o_pkg.sv
// Shared definitions for the 4-state / 2-input / 1-output Moore FSM:
// state and symbol encodings plus the single copy of the transition function.
package fsm_4s2i1o_pkg;

  typedef logic [1:0] state_t;
  typedef logic [1:0] sym_t;

  localparam state_t ST_A = 2'd0;
  localparam state_t ST_B = 2'd1;
  localparam state_t ST_C = 2'd2;
  localparam state_t ST_D = 2'd3;

  localparam sym_t SYM_00 = 2'b00;
  localparam sym_t SYM_01 = 2'b01;
  localparam sym_t SYM_10 = 2'b10;
  localparam sym_t SYM_11 = 2'b11;

  // Transition table (cur: in 00/01/10/11):
  //   A: A/B/A/D   B: C/B/A/D   C: A/D/A/D   D: C/B/A/D
  function automatic state_t next_state(input state_t cur, input sym_t s);
    state_t nxt;
    case (s)
      SYM_10:  nxt = ST_A;
      SYM_11:  nxt = ST_D;
      SYM_01:  nxt = (cur == ST_C) ? ST_D : ST_B;
      default: nxt = ((cur == ST_B) || (cur == ST_D)) ? ST_C : ST_A;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/fsm_4s2i1o_choose.sv
// Picks the next input symbol on the shortest path from cur_i to target_i.
// Every target is reachable in at most two symbols; the two detours are
// C->B (via D) and A->C (via B).
module fsm_4s2i1o_choose
  import fsm_4s2i1o_pkg::*;
(
  input  logic [1:0] cur_i,
  input  logic [1:0] target_i,
  output logic [1:0] sym_o
);

  // Symbol selection by target, with the two detour cases
  always_comb begin
    sym_o = SYM_10;
    case (target_i)
      ST_A:    sym_o = SYM_10;
      ST_B:    sym_o = (cur_i == ST_C) ? SYM_11 : SYM_01;
      ST_C:    sym_o = (cur_i == ST_A) ? SYM_01 : SYM_00;
      default: sym_o = SYM_11;
    endcase
  end

endmodule

// File: rtl/fsm_4s2i1o_steer.sv
// Stimulus generator that steers a downstream 4-state Moore FSM to a requested
// state. Keeps a shadow copy of the driven FSM's state, so the downstream FSM
// must advance exactly once per symbol handshake and be reset alongside this block.
module fsm_4s2i1o_steer
  import fsm_4s2i1o_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       req_val,
  output logic       req_rdy,
  input  logic [1:0] req_target,
  output logic       sym_val,
  input  logic       sym_rdy,
  output logic [1:0] sym,
  output logic       resp_val,
  input  logic       resp_rdy,
  output logic [1:0] resp_steps,
  output logic [1:0] state,
  output logic       out
);

  localparam logic [1:0] CTL_IDLE = 2'd0;
  localparam logic [1:0] CTL_SEND = 2'd1;
  localparam logic [1:0] CTL_RESP = 2'd2;

  logic [1:0] ctl_q,    ctl_d;
  state_t     state_q,  state_d;
  state_t     target_q, target_d;
  logic [1:0] steps_q,  steps_d;
  sym_t       choice;
  state_t     stepped;

  fsm_4s2i1o_choose u_choose (
    .cur_i    (state_q),
    .target_i (target_q),
    .sym_o    (choice)
  );

  assign stepped = next_state(state_q, choice);

  // Control FSM, shadow state and step counter next-state logic
  always_comb begin
    ctl_d    = ctl_q;
    state_d  = state_q;
    target_d = target_q;
    steps_d  = steps_q;
    case (ctl_q)
      CTL_IDLE: begin
        if (req_val) begin
          target_d = req_target;
          steps_d  = 2'd0;
          ctl_d    = CTL_SEND;
        end
      end
      CTL_SEND: begin
        if (state_q == target_q) begin
          ctl_d = CTL_RESP;
        end else if (sym_rdy) begin
          state_d = stepped;
          steps_d = steps_q + 2'd1;
          if (stepped == target_q) ctl_d = CTL_RESP;
        end
      end
      CTL_RESP: begin
        if (resp_rdy) ctl_d = CTL_IDLE;
      end
      default: ctl_d = CTL_IDLE;
    endcase
  end

  // State registers; active-low synchronous reset discards any request in flight
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctl_q    <= CTL_IDLE;
      state_q  <= ST_A;
      target_q <= ST_A;
      steps_q  <= 2'd0;
    end else begin
      ctl_q    <= ctl_d;
      state_q  <= state_d;
      target_q <= target_d;
      steps_q  <= steps_d;
    end
  end

  // All outputs decode registered state only, so they stay stable under stalls
  assign req_rdy    = (ctl_q == CTL_IDLE);
  assign sym_val    = (ctl_q == CTL_SEND) && (state_q != target_q);
  assign sym        = sym_val ? choice : SYM_00;
  assign resp_val   = (ctl_q == CTL_RESP);
  assign resp_steps = steps_q;
  assign state      = state_q;
  assign out        = (state_q == ST_D);

endmodule
